// File: rtl/pc.sv
// -----------------------------------------------------------------------------
// pc : program counter register for the single-cycle RISC-V core.
//
// Holds the address of the instruction being fetched. On every rising edge of
// CLK it loads NextPC, or RESET_VECTOR when RST is high. The next-address mux
// (PC+4, branch or jump target) lives outside this block.
//
// Parameters
//   WIDTH        address width in bits (must be at least 3)
//   RESET_VECTOR value loaded into Pc on reset
//
// Ports
//   CLK        in   1      system clock, rising-edge active
//   RST        in   1      synchronous active-high reset
//   NextPC     in   WIDTH  address to load on the next rising edge
//   Pc         out  WIDTH  current program counter (registered)
//   PcPlus4    out  WIDTH  Pc + 4, modulo 2^WIDTH (combinational)
//   Misaligned out  1      high when Pc[1:0] != 2'b00 (combinational)
// -----------------------------------------------------------------------------
module pc #(
  parameter int unsigned             WIDTH        = 32,
  parameter logic [WIDTH-1:0]        RESET_VECTOR = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] NextPC,
  output logic [WIDTH-1:0] Pc,
  output logic [WIDTH-1:0] PcPlus4,
  output logic             Misaligned
);

  localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;

  // NextPC is taken verbatim: no alignment masking, no stall or enable.
  always_comb begin
    pc_d = NextPC;
  end

  // Reset takes priority over a NextPC presented at the same edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign Pc         = pc_q;
  // Truncating add: FFFF_FFFC + 4 wraps to 0 with no carry out.
  assign PcPlus4    = pc_q + FOUR;
  // Informational only; the core decides whether to trap.
  assign Misaligned = |pc_q[1:0];

endmodule

// File: tb/tb_pc.sv
// -----------------------------------------------------------------------------
// tb_pc : directed self-checking bench for the pc register.
// Inputs are driven on the falling edge; outputs are sampled 1 ns after the
// rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pc;

  logic        CLK;
  logic        RST;
  logic [31:0] NextPC;
  logic [31:0] Pc;
  logic [31:0] PcPlus4;
  logic        Misaligned;

  int checks = 0;
  int errors = 0;

  pc #(
    .WIDTH        (32),
    .RESET_VECTOR (32'h0000_0000)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .NextPC     (NextPC),
    .Pc         (Pc),
    .PcPlus4    (PcPlus4),
    .Misaligned (Misaligned)
  );

  // Clock: 10 ns period, rising edges at 5, 15, 25, ...
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Watchdog so the run always ends.
  initial begin
    #5000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply inputs on the falling edge, then sample just after the rising edge.
  task automatic step(input logic rst, input logic [31:0] nxt);
    @(negedge CLK);
    RST    = rst;
    NextPC = nxt;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST    = 1'b1;
    NextPC = 32'h0000_1234;

    // Reset for two edges, NextPC ignored.
    @(posedge CLK); #1;
    check("reset_pc_edge1", Pc, 32'h0000_0000);
    step(1'b1, 32'h0000_1234);
    check("reset_pc", Pc, 32'h0000_0000);
    check("reset_plus4", PcPlus4, 32'h0000_0004);
    check("reset_misaligned", {31'b0, Misaligned}, 32'h0);

    // Sequential fetch.
    step(1'b0, 32'h0000_0000);
    check("seq_pc_0", Pc, 32'h0000_0000);
    step(1'b0, 32'h0000_0004);
    check("seq_pc_4", Pc, 32'h0000_0004);
    check("seq_plus4_4", PcPlus4, 32'h0000_0008);
    step(1'b0, 32'h0000_0008);
    check("seq_pc_8", Pc, 32'h0000_0008);
    step(1'b0, 32'h0000_000C);
    check("seq_pc_c", Pc, 32'h0000_000C);
    check("seq_plus4_c", PcPlus4, 32'h0000_0010);

    // Jump and hold for three cycles.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h8000_0100);
      check($sformatf("jump_pc_%0d", i), Pc, 32'h8000_0100);
      check($sformatf("jump_plus4_%0d", i), PcPlus4, 32'h8000_0104);
    end

    // Wrap of PcPlus4.
    step(1'b0, 32'hFFFF_FFFC);
    check("wrap_pc", Pc, 32'hFFFF_FFFC);
    check("wrap_plus4", PcPlus4, 32'h0000_0000);
    check("wrap_misaligned", {31'b0, Misaligned}, 32'h0);

    // Misalignment is reported, not masked.
    step(1'b0, 32'h0000_0006);
    check("mis6_pc", Pc, 32'h0000_0006);
    check("mis6_flag", {31'b0, Misaligned}, 32'h1);
    check("mis6_plus4", PcPlus4, 32'h0000_000A);
    step(1'b0, 32'h0000_0003);
    check("mis3_pc", Pc, 32'h0000_0003);
    check("mis3_flag", {31'b0, Misaligned}, 32'h1);
    step(1'b0, 32'h0000_0008);
    check("mis8_flag", {31'b0, Misaligned}, 32'h0);

    // Changes between edges (NextPC and a reset pulse) do not touch Pc.
    @(negedge CLK);
    NextPC = 32'h0000_0055;
    #1;
    check("between_nextpc", Pc, 32'h0000_0008);
    RST = 1'b1;
    #1;
    check("between_rst", Pc, 32'h0000_0008);
    RST    = 1'b0;
    NextPC = 32'h0000_0040;
    @(posedge CLK); #1;
    check("load_40", Pc, 32'h0000_0040);

    // Reset wins over a NextPC at the same edge; release loads next edge.
    step(1'b1, 32'h0000_0044);
    check("rst_priority_pc", Pc, 32'h0000_0000);
    check("rst_priority_plus4", PcPlus4, 32'h0000_0004);
    step(1'b0, 32'h0000_0044);
    check("rst_release_pc", Pc, 32'h0000_0044);
    step(1'b0, 32'h1234_5678);
    check("after_release_pc", Pc, 32'h1234_5678);
    check("after_release_plus4", PcPlus4, 32'h1234_567C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
